move_arbiter: RTL

Front-end controller for `adventure_game`. It synchronizes and debounces four raw direction buttons and queues presses. It arbitrates simultaneous presses by fixed priority and issues each move to the game as a single-cycle one-hot pulse on `n`/`s`/`e`/`w`, separated by an idle gap. Once the game reports `win` or `d`, it locks out further input and counts accepted moves.

---
 rtl/move_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/move_arbiter.sv
// move_arbiter: debounces four direction buttons and issues one-hot move pulses to the game.
// Latency: a press registered before edge E1 pulses for the cycle E(3+DB_CYCLES)..E(4+DB_CYCLES).
// Backpressure: presses queue as one pending flag per direction, with at most one issue every 3 cycles.
//
// Ports:
//   clk                  single system clock, rising edge
//   reset                asynchronous, active-low reset
//   btn_n/s/e/w          raw asynchronous button levels, active-high
//   win, d               game status (won / dead), synchronous to clk
//   n, s, e, w           single-cycle one-hot move pulses (registered decode)
//   moves                saturating count of issued move pulses
//   done                 high once input is locked out (LOCKED)
//
// Parameters:
//   DB_CYCLES            consecutive synchronized samples needed to flip a debounced level (2..255)
//   CNT_W                width of the move counter

module move_arbiter #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_n,
  input  logic             btn_s,
  input  logic             btn_e,
  input  logic             btn_w,
  input  logic             win,
  input  logic             d,
  output logic             n,
  output logic             s,
  output logic             e,
  output logic             w,
  output logic [CNT_W-1:0] moves,
  output logic             done
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  // Direction codes double as the bit index into the per-button vectors.
  // Lower index means higher priority: N > S > E > W.
  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_E = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  // Count value at which the next differing sample is the DB_CYCLES-th one.
  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  localparam logic [CNT_W-1:0] MOVES_MAX = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Input path: synchronizer + debounce + rise detect, one lane per direction
  // ---------------------------------------------------------------------------
  logic [3:0] btn_raw;
  logic [3:0] sync_q;       // first synchronizer stage (may go metastable)
  logic [3:0] level_q;      // debounced level
  logic [3:0] level_dly_q;  // debounced level one cycle later, for edge detect
  logic [7:0] db_cnt_q [4]; // consecutive samples differing from level_q
  logic [3:0] rise;

  assign btn_raw = {btn_w, btn_e, btn_s, btn_n};

  // The debounce counter and level registers sample sync_q directly, so they
  // form the second synchronizer stage: the only logic between the two flop
  // ranks is the compare/increment, and sync_q has a full cycle to settle.
  // Sampling here (rather than behind one more flop) makes the synchronized
  // value seen at edge E2 the first counted sample, giving the E(1+DB_CYCLES)
  // debounced rise and rejecting any press shorter than DB_CYCLES cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync_q      <= btn_raw;
      level_dly_q <= level_q;
      for (int i = 0; i < 4; i++) begin
        if (sync_q[i] == level_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          level_q[i]  <= ~level_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign rise = level_q & ~level_dly_q;

  // ---------------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------------
  logic [1:0] state_q;
  logic [1:0] state_nx;
  logic [1:0] dir_q;
  logic [1:0] dir_nx;
  logic [3:0] pending_q;
  logic [3:0] pending_clr;
  logic       lock_req;

  assign lock_req = (win | d) && (state_q != ST_LOCKED);

  always_comb begin
    state_nx = state_q;
    dir_nx   = dir_q;
    case (state_q)
      ST_IDLE: begin
        // Latch only when not locking out this cycle: a win/dead report in
        // IDLE must not start a move even with requests waiting.
        if (|pending_q && !lock_req) begin
          state_nx = ST_ISSUE;
          if (pending_q[DIR_N])      dir_nx = DIR_N;
          else if (pending_q[DIR_S]) dir_nx = DIR_S;
          else if (pending_q[DIR_E]) dir_nx = DIR_E;
          else                       dir_nx = DIR_W;
        end
      end
      ST_ISSUE:  state_nx = ST_GAP;
      ST_GAP:    state_nx = ST_IDLE;
      default:   state_nx = ST_LOCKED;
    endcase
    // Lockout overrides every other transition; an ISSUE cycle still
    // completes its pulse and count because those are decoded from state_q.
    if (lock_req) begin
      state_nx = ST_LOCKED;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_N;
    end else begin
      state_q <= state_nx;
      dir_q   <= dir_nx;
    end
  end

  // Served flag is cleared as ISSUE ends. A new rise on the same edge wins
  // over the clear so that press is not lost; a rise while the flag is still
  // set simply merges into it.
  assign pending_clr = (state_q == ST_ISSUE) ? (4'b0001 << dir_q) : 4'b0000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
    end else if (state_q == ST_LOCKED) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~pending_clr) | rise;
    end
  end

  // Move counter saturates rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      moves <= '0;
    end else if ((state_q == ST_ISSUE) && (moves != MOVES_MAX)) begin
      moves <= moves + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state and dir only
  // ---------------------------------------------------------------------------
  assign n    = (state_q == ST_ISSUE) && (dir_q == DIR_N);
  assign s    = (state_q == ST_ISSUE) && (dir_q == DIR_S);
  assign e    = (state_q == ST_ISSUE) && (dir_q == DIR_E);
  assign w    = (state_q == ST_ISSUE) && (dir_q == DIR_W);
  assign done = (state_q == ST_LOCKED);

endmodule
